// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmit path: byte width,
// default FIFO depth and the drain state machine encoding.
package uart_pkg;

  localparam int BYTE_W             = 8;
  localparam int DEFAULT_DEPTH_LOG2 = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } drain_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO: circular buffer with separate occupancy counter,
// synchronous flush and an asynchronous active-low reset.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  pop_ok;
  logic                  push_ok;

  // The level counter only reaches 2**DEPTH_LOG2 when full, so its MSB is the full flag.
  assign full_o  = level_q[DEPTH_LOG2];
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o && !flush_i;
  assign push_ok = push_i && (!full_o || pop_ok) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
      else if (pop_ok && !push_ok) level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmit front end: byte FIFO plus a drain FSM pacing on tx_busy.
// Optional registered low-level interrupt enabled by UART_TX_FIFO_THRESH_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
`ifdef UART_TX_FIFO_THRESH_EN
  ,
  parameter int LOW_MARK   = 2
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [BYTE_W-1:0]   wr_data,
  input  logic                flush,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  input  logic                ovf_clr,
  output logic [BYTE_W-1:0]   tx_data,
  output logic                tx_wr,
  input  logic                tx_busy,
  output logic                low_irq
);

  drain_state_e        state_q, state_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic [BYTE_W-1:0]   head;
  logic                pop;
  logic                overflow_q, overflow_d;

  sync_fifo #(
    .WIDTH      (BYTE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_en),
    .wdata_i (wr_data),
    .pop_i   (pop),
    .flush_i (flush),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  // A pop is only taken while the uart is idle, so the strobe never lands on a busy uart.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !tx_busy && !flush) begin
          pop       = 1'b1;
          tx_data_d = head;
          state_d   = ISSUE;
        end
      end
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (wr_en && full && !pop) overflow_d = 1'b1;
    else if (ovf_clr)          overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_wr    = (state_q == ISSUE);
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;

`ifdef UART_TX_FIFO_THRESH_EN
  localparam logic [DEPTH_LOG2:0] LOW_MARK_W = (DEPTH_LOG2 + 1)'(LOW_MARK);

  logic low_irq_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) low_irq_q <= 1'b0;
    else        low_irq_q <= (level <= LOW_MARK_W);
  end

  assign low_irq = low_irq_q;
`else
  assign low_irq = 1'b0;
`endif

endmodule
